eth_rx_frame_ctrl: RTL
======================

// Module: eth_rx_frame_ctrl
// PURPOSE
// Sequences one received Ethernet frame after the preamble/SFD detector fires: forwards payload bytes
// into the payload buffer, enforces min/max length, overflow and stall timeout, then raises frame_end
// back to the detector and issues a commit/discard decision to the buffer. Sits between the SFD
// detector and the payload buffer; enforces a quiet inter-frame gap before re-arming.
// PARAMETERS
// MIN_LEN      64    minimum legal byte count (SFD excluded), shorter = runt
// MAX_LEN      1518  maximum legal byte count; byte MAX_LEN+1 = too long
// TIMEOUT      64    cycles without rx_byte_valid while rx_dv high before abort
// IFG_CYCLES   12    consecutive rx_dv-low cycles required before re-arm
// LEN_W        11    width of byte counter / frame_len
// PORTS
// clk          in   1      clock
// rst          in   1      reset, asynchronous, active-high
// sfd_pulse    in   1      one-cycle start pulse from SFD detector (its frame_valid)
// rx_dv        in   1      carrier/data-valid from PHY side; low = frame over
// rx_byte      in   8      received byte
// rx_byte_valid in  1      rx_byte strobe
// buf_ready    in   1      payload buffer can accept a byte this cycle
// frame_end    out  1      one-cycle pulse to detector/capture: frame finished
// wr_en        out  1      payload byte write strobe
// wr_data      out  8      payload byte
// commit       out  1      one-cycle pulse: keep written frame
// discard      out  1      one-cycle pulse: drop written frame
// frame_len    out  LEN_W  bytes accepted in last frame, valid with commit/discard
// err_code     out  3      0 ok,1 runt,2 too long,3 overflow,4 timeout; valid with commit/discard
// busy         out  1      high in RECV/DROP/DONE/IFG
// BEHAVIOUR
// - All outputs registered; reset value 0 for every output; state=IDLE, counters 0.
// - IDLE: sfd_pulse -> RECV, byte_cnt=0, stall_cnt=0. Bytes without sfd_pulse ignored.
// - RECV, rx_byte_valid=1: buf_ready=1 and byte_cnt<MAX_LEN -> wr_en=1, wr_data=rx_byte next
//   cycle (latency 1), byte_cnt++; buf_ready=0 -> err=3, DROP; byte_cnt==MAX_LEN -> err=2, DROP.
// - RECV, rx_byte_valid=0 and rx_dv=1: stall_cnt++; stall_cnt reaching TIMEOUT-1 -> err=4, DROP.
//   stall_cnt clears on every valid byte.
// - RECV, rx_dv=0 -> DONE; same-cycle rx_byte_valid byte is processed first (accepted or errored).
//   At DONE: byte_cnt<MIN_LEN -> err=1 else err=0.
// - DROP: no writes; wait for rx_dv=0, then DONE with latched err (first error wins).
// - DONE (1 cycle): frame_end=1, frame_len=byte_cnt, err_code set; commit=1 if err=0 else discard=1.
//   commit and discard never both high. -> IFG.
// - IFG: count consecutive rx_dv=0 cycles; rx_dv=1 restarts count; count==IFG_CYCLES -> IDLE.
//   sfd_pulse during IFG/RECV/DROP/DONE ignored.
// - frame_len/err_code hold until next DONE. wr_en never asserted outside RECV.
// - Reset mid-frame: immediately IDLE, no commit/discard emitted; buffer relies on its own reset.
// - Counters saturate; byte_cnt cannot exceed MAX_LEN (LEN_W must hold MAX_LEN).
// STRUCTURE
// - Shared package eth_rx_pkg: state encodings (IDLE,RECV,DROP,DONE,IFG), ERR_OK/RUNT/LONG/OVF/TMO
//   constants, ETH_MIN_LEN/ETH_MAX_LEN defaults.
// - One natural sub-module: eth_rx_gap_timer (reloadable down-counter used for stall timeout and IFG).
// - Top-level FSM + byte counter in this module.
// TESTING
// 1 sfd_pulse, 64 bytes 0x00..0x3F valid every cycle, buf_ready=1, rx_dv low -> 64 wr_en, frame_end,
//   commit, frame_len=64, err_code=0.
// 2 sfd_pulse, 10 bytes, rx_dv low -> 10 writes, discard, frame_len=10, err_code=1.
// 3 sfd_pulse, 1520 bytes -> 1518 writes, DROP, after rx_dv low discard, frame_len=1518, err_code=2.
// 4 buf_ready=0 on byte 20 of 100 -> 19 writes, discard, err_code=3, frame_len=19.
// 5 rx_dv held high, bytes stop after 30 for 64 cycles -> discard, err_code=4; new sfd_pulse before
//   12 quiet cycles ignored, after 12 quiet cycles accepted.
// 6 assert rst mid-RECV after 40 bytes -> all outputs 0 next edge, no commit/discard, next frame ok.

Source files
------------

// File: rtl/eth_rx_pkg.sv
// Shared types and defaults for the Ethernet receive frame controller.
package eth_rx_pkg;

  localparam int unsigned ETH_MIN_LEN    = 64;
  localparam int unsigned ETH_MAX_LEN    = 1518;
  localparam int unsigned ETH_TIMEOUT    = 64;
  localparam int unsigned ETH_IFG_CYCLES = 12;
  localparam int unsigned ETH_LEN_W      = 11;

  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StDrop,
    StDone,
    StIfg
  } state_e;

  typedef enum logic [2:0] {
    ERR_OK   = 3'd0,
    ERR_RUNT = 3'd1,
    ERR_LONG = 3'd2,
    ERR_OVF  = 3'd3,
    ERR_TMO  = 3'd4
  } err_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/eth_rx_frame_ctrl_if.sv
// Byte stream from the PHY/SFD side in, payload buffer writes and frame verdict out.
interface eth_rx_frame_ctrl_if #(
  parameter int unsigned LEN_W = 11
);
  logic             sfd_pulse;
  logic             rx_dv;
  logic [7:0]       rx_byte;
  logic             rx_byte_valid;
  logic             buf_ready;
  logic             frame_end;
  logic             wr_en;
  logic [7:0]       wr_data;
  logic             commit;
  logic             discard;
  logic [LEN_W-1:0] frame_len;
  logic [2:0]       err_code;
  logic             busy;

  modport master (
    output sfd_pulse, rx_dv, rx_byte, rx_byte_valid, buf_ready,
    input  frame_end, wr_en, wr_data, commit, discard, frame_len, err_code, busy
  );

  modport slave (
    input  sfd_pulse, rx_dv, rx_byte, rx_byte_valid, buf_ready,
    output frame_end, wr_en, wr_data, commit, discard, frame_len, err_code, busy
  );
endinterface

// File: rtl/eth_rx_gap_timer.sv
// Reloadable saturating down-counter; expire fires on a decrement request at zero.
module eth_rx_gap_timer #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expire
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = dec && !load && (cnt_q == '0);

endmodule

// File: rtl/eth_rx_frame_ctrl.sv
// Per-frame receive sequencer: forwards payload bytes, checks length/overflow/stall,
// issues commit or discard, then holds off re-arming until the inter-frame gap is quiet.
module eth_rx_frame_ctrl
  import eth_rx_pkg::*;
#(
  parameter int unsigned MIN_LEN    = ETH_MIN_LEN,
  parameter int unsigned MAX_LEN    = ETH_MAX_LEN,
  parameter int unsigned TIMEOUT    = ETH_TIMEOUT,
  parameter int unsigned IFG_CYCLES = ETH_IFG_CYCLES,
  parameter int unsigned LEN_W      = ETH_LEN_W
) (
  input logic                clk,
  input logic                rst,
  eth_rx_frame_ctrl_if.slave bus
);

  localparam int unsigned TmrW = $clog2(max_u(TIMEOUT, IFG_CYCLES) + 1);
  localparam logic [LEN_W-1:0] MaxLen    = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] MinLen    = LEN_W'(MIN_LEN);
  localparam logic [TmrW-1:0]  StallLoad = TmrW'(TIMEOUT - 1);
  localparam logic [TmrW-1:0]  IfgLoad   = TmrW'(IFG_CYCLES - 1);

  state_e           state_q;
  logic [LEN_W-1:0] byte_cnt_q;
  err_e             err_q;
  logic             frame_end_q;
  logic             wr_en_q;
  logic [7:0]       wr_data_q;
  logic             commit_q;
  logic             discard_q;
  logic [LEN_W-1:0] frame_len_q;
  err_e             err_code_q;
  logic             busy_q;

  err_e             byte_err;
  logic             byte_ok;
  logic [LEN_W-1:0] recv_cnt;
  err_e             recv_done_err;

  logic             tmr_load;
  logic [TmrW-1:0]  tmr_load_val;
  logic             tmr_dec;
  logic             tmr_expire;

  // Classify the byte presented this cycle; the verdict also covers a byte that
  // arrives in the same cycle rx_dv drops.
  always_comb begin
    byte_err = ERR_OK;
    if (bus.rx_byte_valid) begin
      if (!bus.buf_ready) begin
        byte_err = ERR_OVF;
      end else if (byte_cnt_q >= MaxLen) begin
        byte_err = ERR_LONG;
      end
    end
    byte_ok  = bus.rx_byte_valid && (byte_err == ERR_OK);
    recv_cnt = byte_ok ? byte_cnt_q + 1'b1 : byte_cnt_q;
    if (byte_err != ERR_OK) begin
      recv_done_err = byte_err;
    end else if (recv_cnt < MinLen) begin
      recv_done_err = ERR_RUNT;
    end else begin
      recv_done_err = ERR_OK;
    end
  end

  // One timer serves both the stall watchdog in RECV and the quiet-gap count in IFG.
  always_comb begin
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    case (state_q)
      StIdle: begin
        tmr_load     = bus.sfd_pulse;
        tmr_load_val = StallLoad;
      end
      StRecv: begin
        tmr_load     = bus.rx_byte_valid;
        tmr_load_val = StallLoad;
        tmr_dec      = !bus.rx_byte_valid && bus.rx_dv;
      end
      StDone: begin
        tmr_load     = 1'b1;
        tmr_load_val = IfgLoad;
      end
      StIfg: begin
        tmr_load     = bus.rx_dv;
        tmr_load_val = IfgLoad;
        tmr_dec      = !bus.rx_dv;
      end
      default: ;
    endcase
  end

  eth_rx_gap_timer #(
    .W(TmrW)
  ) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .expire   (tmr_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      byte_cnt_q  <= '0;
      err_q       <= ERR_OK;
      frame_end_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      commit_q    <= 1'b0;
      discard_q   <= 1'b0;
      frame_len_q <= '0;
      err_code_q  <= ERR_OK;
      busy_q      <= 1'b0;
    end else begin
      frame_end_q <= 1'b0;
      commit_q    <= 1'b0;
      discard_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      case (state_q)
        StIdle: begin
          busy_q <= bus.sfd_pulse;
          if (bus.sfd_pulse) begin
            state_q    <= StRecv;
            byte_cnt_q <= '0;
            err_q      <= ERR_OK;
          end
        end
        StRecv: begin
          busy_q     <= 1'b1;
          byte_cnt_q <= recv_cnt;
          if (byte_ok) begin
            wr_en_q   <= 1'b1;
            wr_data_q <= bus.rx_byte;
          end
          if (!bus.rx_dv) begin
            state_q     <= StDone;
            frame_end_q <= 1'b1;
            frame_len_q <= recv_cnt;
            err_code_q  <= recv_done_err;
            commit_q    <= (recv_done_err == ERR_OK);
            discard_q   <= (recv_done_err != ERR_OK);
          end else if (byte_err != ERR_OK) begin
            err_q   <= byte_err;
            state_q <= StDrop;
          end else if (tmr_expire) begin
            err_q   <= ERR_TMO;
            state_q <= StDrop;
          end
        end
        StDrop: begin
          busy_q <= 1'b1;
          if (!bus.rx_dv) begin
            state_q     <= StDone;
            frame_end_q <= 1'b1;
            frame_len_q <= byte_cnt_q;
            err_code_q  <= err_q;
            commit_q    <= (err_q == ERR_OK);
            discard_q   <= (err_q != ERR_OK);
          end
        end
        StDone: begin
          busy_q  <= 1'b1;
          state_q <= StIfg;
        end
        StIfg: begin
          busy_q <= !tmr_expire;
          if (tmr_expire) begin
            state_q <= StIdle;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.frame_end = frame_end_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.commit    = commit_q;
  assign bus.discard   = discard_q;
  assign bus.frame_len = frame_len_q;
  assign bus.err_code  = err_code_q;
  assign bus.busy      = busy_q;

endmodule
